// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial link (transmitter and receiver).
package serial_pkg;

  localparam int              BYTE_W     = 8;
  localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;

  typedef logic [1:0] state_t;
  localparam state_t SEARCH = 2'd0;
  localparam state_t COUNT  = 2'd1;
  localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/serial_shift_in.sv
// Serial input shift register with the candidate byte and its comma comparator.
module serial_shift_in
  import serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_BYTE
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_i,
  output logic [BYTE_W-1:0] nxt_o,
  output logic              is_comma_o
);

  logic [BYTE_W-1:0] sr_q;

  assign nxt_o      = {sr_q[BYTE_W-2:0], data_i};
  assign is_comma_o = (nxt_o == COMMA);

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= nxt_o;
  end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma-based byte alignment, lock FSM and
// registered byte outputs for the clk_4f domain logic.
module serial_paralelo
  import serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_BYTE,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic [BYTE_W-1:0] nxt;
  logic              is_comma;

  state_t            state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [BYTE_W-1:0] data_q,      data_d;
  logic              valid_q,     valid_d;
  logic              strobe_q,    strobe_d;
  logic              active_q,    active_d;

  logic              boundary;
  logic [CNT_W-1:0]  cnt_inc;

  serial_shift_in #(.COMMA(COMMA)) u_shift_in (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_i     (data_in),
    .nxt_o      (nxt),
    .is_comma_o (is_comma)
  );

  assign boundary = (bit_cnt_q == 3'd7);
  assign cnt_inc  = comma_cnt_q + CNT_W'(1);

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    active_d    = active_q;

    case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt; a match redefines the byte phase.
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = CNT_W'(1);
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule
